// File: rtl/param_number_analyzer.sv
// Number analyzer: classifies a captured unsigned operand as odd, Fibonacci
// and/or binary palindrome. The Fibonacci and palindrome checks are iterative
// engines that run in parallel while the FSM is in RUN.
module param_number_analyzer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_number,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             out_ready,
    output logic             is_odd,
    output logic             is_fibonacci,
    output logic             is_palindrome
);

    localparam int unsigned IW = $clog2(WIDTH);
    // Two extra bits keep a and b (and a + b) from wrapping for any operand.
    localparam int unsigned FW = WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             fib_en_q, fib_en_d;
    logic             pal_en_q, pal_en_d;
    logic [FW-1:0]    a_q, a_d;
    logic [FW-1:0]    b_q, b_d;
    logic             fib_done_q, fib_done_d;
    logic             fib_res_q, fib_res_d;
    logic             pal_started_q, pal_started_d;
    logic             pal_done_q, pal_done_d;
    logic             pal_res_q, pal_res_d;
    logic [IW-1:0]    m_q, m_d;
    logic [IW-1:0]    i_q, i_d;
    logic             odd_q, odd_d;
    logic             fib_q, fib_d;
    logic             pal_q, pal_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [FW-1:0]    n_ext;
    logic [IW-1:0]    msb_idx;
    logic [IW+1:0]    i_dbl;
    logic [IW+1:0]    m_ext;

    assign n_ext = {2'b00, n_q};
    // 2*(i+1) >= m is the "pointers have met or crossed" test i+1 >= m-(i+1).
    assign i_dbl = (IW+2)'(i_q) + (IW+2)'(i_q) + (IW+2)'(2);
    assign m_ext = (IW+2)'(m_q);

    // Index of the most significant set bit of the captured operand (0 when n == 0).
    always_comb begin
        msb_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (n_q[k]) begin
                msb_idx = IW'(k);
            end
        end
    end

    // Next-state logic for the FSM and both engines.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        fib_en_d      = fib_en_q;
        pal_en_d      = pal_en_q;
        a_d           = a_q;
        b_d           = b_q;
        fib_done_d    = fib_done_q;
        fib_res_d     = fib_res_q;
        pal_started_d = pal_started_q;
        pal_done_d    = pal_done_q;
        pal_res_d     = pal_res_q;
        m_d           = m_q;
        i_d           = i_q;
        odd_d         = odd_q;
        fib_d         = fib_q;
        pal_d         = pal_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (enable) begin
                    state_d       = StRun;
                    n_d           = in_number;
                    fib_en_d      = mode[1];
                    pal_en_d      = mode[2];
                    a_d           = '0;
                    b_d           = FW'(1);
                    fib_done_d    = 1'b0;
                    fib_res_d     = 1'b0;
                    pal_started_d = 1'b0;
                    pal_done_d    = 1'b0;
                    pal_res_d     = 1'b0;
                    m_d           = '0;
                    i_d           = '0;
                    odd_d         = in_number[0] & mode[0];
                    fib_d         = 1'b0;
                    pal_d         = 1'b0;
                end
            end
            StRun: begin
                // Fibonacci engine: walk the sequence until it reaches or passes n.
                if (!fib_done_q) begin
                    if (!fib_en_q) begin
                        fib_done_d = 1'b1;
                        fib_res_d  = 1'b0;
                    end else if (a_q == n_ext) begin
                        fib_done_d = 1'b1;
                        fib_res_d  = 1'b1;
                    end else if (a_q > n_ext) begin
                        fib_done_d = 1'b1;
                        fib_res_d  = 1'b0;
                    end else begin
                        a_d = b_q;
                        b_d = a_q + b_q;
                    end
                end
                // Palindrome engine: first cycle finds the MSB, then compares bit pairs
                // walking inward from both ends of the significant bits.
                if (!pal_done_q) begin
                    if (!pal_en_q) begin
                        pal_done_d = 1'b1;
                        pal_res_d  = 1'b0;
                    end else if (!pal_started_q) begin
                        if (msb_idx == '0) begin
                            pal_done_d = 1'b1;
                            pal_res_d  = 1'b1;
                        end else begin
                            pal_started_d = 1'b1;
                            m_d           = msb_idx;
                            i_d           = '0;
                        end
                    end else if (n_q[i_q] != n_q[m_q - i_q]) begin
                        pal_done_d = 1'b1;
                        pal_res_d  = 1'b0;
                    end else if (i_dbl >= m_ext) begin
                        pal_done_d = 1'b1;
                        pal_res_d  = 1'b1;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
                if (fib_done_d && pal_done_d) begin
                    state_d = StDone;
                    fib_d   = fib_res_d;
                    pal_d   = pal_res_d;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d  = (state_d == StRun);
        ready_d = (state_d == StDone);
    end

    // State and result registers; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            n_q           <= '0;
            fib_en_q      <= 1'b0;
            pal_en_q      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            fib_done_q    <= 1'b0;
            fib_res_q     <= 1'b0;
            pal_started_q <= 1'b0;
            pal_done_q    <= 1'b0;
            pal_res_q     <= 1'b0;
            m_q           <= '0;
            i_q           <= '0;
            odd_q         <= 1'b0;
            fib_q         <= 1'b0;
            pal_q         <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            fib_en_q      <= fib_en_d;
            pal_en_q      <= pal_en_d;
            a_q           <= a_d;
            b_q           <= b_d;
            fib_done_q    <= fib_done_d;
            fib_res_q     <= fib_res_d;
            pal_started_q <= pal_started_d;
            pal_done_q    <= pal_done_d;
            pal_res_q     <= pal_res_d;
            m_q           <= m_d;
            i_q           <= i_d;
            odd_q         <= odd_d;
            fib_q         <= fib_d;
            pal_q         <= pal_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    assign busy          = busy_q;
    assign out_ready     = ready_q;
    assign is_odd        = odd_q;
    assign is_fibonacci  = fib_q;
    assign is_palindrome = pal_q;

endmodule

// File: doc/param_number_analyzer.md
PARAM_NUMBER_ANALYZER -- requirements
Module: param_number_analyzer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 2..64.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: start request, sampled on the rising edge.
REQ-005 The block SHALL have port in_number, input, WIDTH bits: unsigned operand, captured on accept.
REQ-006 The block SHALL have port mode, input, 3 bits: check select, captured on accept; bit0 = odd, bit1 = fibonacci, bit2 = binary palindrome.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a request is in progress (RUN state).
REQ-008 The block SHALL have port out_ready, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have ports is_odd, is_fibonacci and is_palindrome, outputs, 1 bit each: registered results, held stable until the next accept.

Function
REQ-010 The FSM SHALL have the states IDLE, RUN and DONE.
- busy = (state == RUN).
- out_ready = (state == DONE).
REQ-011 The block SHALL accept a request when enable = 1 in IDLE or DONE.
- On accept: capture in_number and mode, clear all result flags, enter RUN.
- enable in RUN SHALL be ignored.
REQ-012 DONE SHALL last exactly one cycle, then go to IDLE, unless a new request is accepted in that cycle, in which case go directly to RUN.
REQ-013 is_odd SHALL equal captured in_number[0] AND mode[0], written on the accept edge.
REQ-014 Fibonacci engine:
- Registers a, b, each WIDTH+2 bits, initialised a = 0, b = 1 on accept.
- Each RUN cycle: if a == n, set hit and stop; if a > n, set miss and stop; else a <= b, b <= a + b.
- No overflow SHALL be possible for any WIDTH-bit operand.
REQ-015 Palindrome engine, first RUN cycle:
- Compute m = index of the most significant 1 of n.
- If n == 0 or m == 0, the result is true and the engine stops.
- Otherwise set i = 0.
REQ-016 Palindrome engine, each later RUN cycle:
- Compare n[i] with n[m-i].
- On mismatch, the result is false and the engine stops.
- Else if i+1 >= m-(i+1), the result is true and the engine stops.
- Else i <= i+1.
REQ-017 An engine whose mode bit is 0 SHALL report done in the first RUN cycle with result 0.
REQ-018 RUN SHALL exit to DONE on the edge after both engines are done.
- is_fibonacci and is_palindrome are written on that same edge.
- Minimum latency: out_ready high in cycle 2 after the accept edge.
REQ-019 Leading zeros SHALL NOT take part in the palindrome test; n = 0 counts as a palindrome and as a Fibonacci number.
REQ-020 mode = 000 SHALL produce all-zero results with out_ready in cycle 2.

Reset
REQ-021 reset = 0 SHALL immediately, independent of the clock, force:
- state IDLE;
- busy, out_ready, is_odd, is_fibonacci and is_palindrome to 0;
- all engine registers to 0.
REQ-022 reset asserted mid-RUN SHALL abort the request with no out_ready pulse.
- After release, the block SHALL be in IDLE and accept on the first enable.
REQ-023 enable SHALL be ignored while reset = 0.

Verification
REQ-024 WIDTH=32, n=21, mode=111 -> out_ready in cycle 10 after accept; is_odd=1, is_fibonacci=1, is_palindrome=1; busy high in cycles 1-9.
REQ-025 n=4, mode=111 -> out_ready in cycle 7; is_odd=0, is_fibonacci=0, is_palindrome=0.
REQ-026 n=0, mode=111 -> out_ready in cycle 2; is_odd=0, is_fibonacci=1, is_palindrome=1.
- n=9, mode=001 -> out_ready in cycle 2; is_odd=1, others 0.
REQ-027 WIDTH=8, n=255, mode=010 -> is_fibonacci=0 with no wrap.
- n=233, mode=010 -> is_fibonacci=1.
REQ-028 Handshake and reset cases:
- enable held high through n=21 -> a second request is accepted in the DONE cycle, back-to-back.
- enable pulsed during RUN -> ignored.
- reset pulsed in RUN cycle 4 -> all outputs 0, no out_ready; the next request completes normally.
